// File: rtl/dm_responder_if.sv
// Bus bundle between the pipelined MIPS core (or its bench) and the memory responder:
// fetch port, data port, instruction-RAM loader and the store-log drain port.
interface dm_responder_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        prog_we;
    logic [11:0] prog_addr;
    logic [31:0] prog_data;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [7:0]  log_drop;
    logic [15:0] err_count;

    modport master (
        output i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
               prog_we, prog_addr, prog_data, log_ready,
        input  i_inst_rdata, m_data_rdata, log_valid, log_pc, log_addr, log_data,
               log_drop, err_count
    );

    modport slave (
        input  i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
               prog_we, prog_addr, prog_data, log_ready,
        output i_inst_rdata, m_data_rdata, log_valid, log_pc, log_addr, log_data,
               log_drop, err_count
    );
endinterface

// File: rtl/dm_responder.sv
// Memory-side responder: combinational instruction/data reads, byte-lane merged stores
// into a word RAM, and a first-word fall-through FIFO logging every committed store.
module dm_responder #(
    parameter int          DM_WORDS  = 3072,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter int          IM_WORDS  = 4096,
    parameter int          LOG_DEPTH = 8
) (
    input logic           clk,
    input logic           reset,
    dm_responder_if.slave bus
);
    localparam int          DM_AW    = $clog2(DM_WORDS);
    localparam int          IM_AW    = $clog2(IM_WORDS);
    localparam int          LP_W     = $clog2(LOG_DEPTH);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);
    localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    logic [31:0] im [IM_WORDS];
    logic [31:0] dm [DM_WORDS];
    log_entry_t  log_mem [LOG_DEPTH];

    logic [LP_W-1:0] rd_ptr;
    logic [LP_W-1:0] wr_ptr;
    logic [LP_W:0]   count;
    logic [7:0]      drop_cnt;
    logic [15:0]     err_cnt;

    // Fetch: the subtraction wraps below IM_BASE, so one unsigned compare covers both bounds.
    logic [31:0] im_off;
    logic        im_hit;
    assign im_off = bus.i_inst_addr - IM_BASE;
    assign im_hit = (im_off < IM_BYTES) && (bus.i_inst_addr[1:0] == 2'b00);
    assign bus.i_inst_rdata = im_hit ? im[im_off[IM_AW+1:2]] : 32'h0;

    logic [DM_AW-1:0] dm_idx;
    logic             dm_hit;
    logic             store_ok;
    logic             store_err;
    logic [31:0]      merged;
    assign dm_hit    = bus.m_data_addr < DM_BYTES;
    assign dm_idx    = bus.m_data_addr[DM_AW+1:2];
    assign store_ok  = (bus.m_data_byteen != 4'h0) && dm_hit;
    assign store_err = (bus.m_data_byteen != 4'h0) && !dm_hit;
    assign bus.m_data_rdata = dm_hit ? dm[dm_idx] : 32'h0;

    always_comb begin
        merged = dm[dm_idx];
        for (int i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
        end
    end

    // A pop in the same cycle frees the slot the push needs, so a full FIFO only drops without one.
    logic full;
    logic pop;
    logic push_ok;
    logic drop;
    assign full    = count == (LP_W+1)'(LOG_DEPTH);
    assign pop     = (count != '0) && bus.log_ready;
    assign push_ok = store_ok && (!full || pop);
    assign drop    = store_ok && full && !pop;

    // NOTE: the data RAM must read as zero straight after reset, so every word is cleared in
    // the reset branch; the IM and the log storage hold no reset and live in their own blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (store_ok) dm[dm_idx] <= merged;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            count <= count + (LP_W+1)'(push_ok) - (LP_W+1)'(pop);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            if (store_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) log_mem[wr_ptr] <= '{pc: bus.m_inst_addr,
                                          addr: {bus.m_data_addr[31:2], 2'b00},
                                          data: merged};
    end

    // Program loading stays live during reset so a test image can be written before release.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (32'(bus.prog_addr) < 32'(IM_WORDS)))
            im[bus.prog_addr[IM_AW-1:0]] <= bus.prog_data;
    end

    assign bus.log_valid = count != '0;
    assign bus.log_pc    = log_mem[rd_ptr].pc;
    assign bus.log_addr  = log_mem[rd_ptr].addr;
    assign bus.log_data  = log_mem[rd_ptr].data;
    assign bus.log_drop  = drop_cnt;
    assign bus.err_count = err_cnt;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus randomized traffic compared against a
// behavioural memory/queue model of the responder.
module tb_dm_responder;
    localparam int          DM_WORDS  = 3072;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int          IM_WORDS  = 4096;
    localparam int          LOG_DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    dm_responder_if bus ();

    dm_responder #(
        .DM_WORDS (DM_WORDS),
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS),
        .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_dm [DM_WORDS];
    logic [31:0] ref_im [IM_WORDS];
    entry_t      ref_log [$];
    int          ref_drop = 0;
    int          ref_err  = 0;

    function automatic logic [31:0] ref_read(logic [31:0] a);
        if (a < DM_WORDS * 4) return ref_dm[a / 4];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_fetch(logic [31:0] a);
        if (a >= IM_BASE && a < IM_BASE + 32'(IM_WORDS * 4) && a[1:0] == 2'b00)
            return ref_im[(a - IM_BASE) / 4];
        return 32'h0;
    endfunction

    task automatic model_clear();
        foreach (ref_dm[i]) ref_dm[i] = 32'h0;
        ref_log.delete();
        ref_drop = 0;
        ref_err  = 0;
    endtask

    // Applies the effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        logic [31:0] w;
        if (bus.prog_we && bus.prog_addr < IM_WORDS) ref_im[bus.prog_addr] = bus.prog_data;
        if (reset) begin
            model_clear();
            return;
        end
        if (ref_log.size() > 0 && bus.log_ready) void'(ref_log.pop_front());
        if (bus.m_data_byteen != 4'h0) begin
            if (bus.m_data_addr < DM_WORDS * 4) begin
                w = ref_dm[bus.m_data_addr / 4];
                for (int i = 0; i < 4; i++)
                    if (bus.m_data_byteen[i]) w[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
                ref_dm[bus.m_data_addr / 4] = w;
                if (ref_log.size() < LOG_DEPTH)
                    ref_log.push_back('{bus.m_inst_addr, bus.m_data_addr & ~32'd3, w});
                else if (ref_drop < 255)
                    ref_drop++;
            end else if (ref_err < 65535) begin
                ref_err++;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 32'(bus.log_valid), 32'(ref_log.size() != 0));
        if (ref_log.size() != 0) begin
            chk({tag, ".log_pc"},   bus.log_pc,   ref_log[0].pc);
            chk({tag, ".log_addr"}, bus.log_addr, ref_log[0].addr);
            chk({tag, ".log_data"}, bus.log_data, ref_log[0].data);
        end
        chk({tag, ".drop"},  32'(bus.log_drop),  32'(ref_drop));
        chk({tag, ".err"},   32'(bus.err_count), 32'(ref_err));
        chk({tag, ".rdata"}, bus.m_data_rdata,   ref_read(bus.m_data_addr));
        chk({tag, ".inst"},  bus.i_inst_rdata,   ref_fetch(bus.i_inst_addr));
    endtask

    task automatic drive_store(logic [31:0] a, logic [31:0] d, logic [3:0] be, logic [31:0] pc);
        bus.m_data_addr   = a;
        bus.m_data_wdata  = d;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] prior;
        bus.i_inst_addr   = IM_BASE;
        bus.m_data_addr   = 32'h0;
        bus.m_data_wdata  = 32'h0;
        bus.m_data_byteen = 4'h0;
        bus.m_inst_addr   = 32'h0;
        bus.prog_we       = 1'b0;
        bus.prog_addr     = 12'h0;
        bus.prog_data     = 32'h0;
        bus.log_ready     = 1'b0;

        // Program load while reset is held.
        for (int i = 0; i < 16; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 12'(i);
            bus.prog_data = (i == 0) ? 32'h3C01_0001 : $urandom;
            cycle();
        end
        bus.prog_we     = 1'b0;
        bus.m_data_addr = 32'h10;
        #1;
        chk("reset.valid", 32'(bus.log_valid), 32'h0);
        chk("reset.drop",  32'(bus.log_drop),  32'h0);
        chk("reset.err",   32'(bus.err_count), 32'h0);
        chk("reset.rdata", bus.m_data_rdata,   32'h0);
        reset = 1'b0;
        #1;

        // Word store.
        drive_store(32'h10, 32'h1234_5678, 4'hF, 32'h3004);
        cycle();
        bus.m_data_byteen = 4'h0;
        #1;
        chk("word.rdata",    bus.m_data_rdata,   32'h1234_5678);
        chk("word.valid",    32'(bus.log_valid), 32'h1);
        chk("word.log_pc",   bus.log_pc,         32'h3004);
        chk("word.log_addr", bus.log_addr,       32'h10);
        chk("word.log_data", bus.log_data,       32'h1234_5678);
        check_all("word");

        // Byte store into lane 2 of the same word.
        drive_store(32'h12, 32'h00AB_0000, 4'b0100, 32'h3008);
        cycle();
        bus.m_data_byteen = 4'h0;
        bus.m_data_addr   = 32'h10;
        #1;
        chk("byte.rdata", bus.m_data_rdata, 32'h12AB_5678);
        bus.log_ready = 1'b1;
        cycle();
        chk("byte.log_addr", bus.log_addr, 32'h10);
        chk("byte.log_data", bus.log_data, 32'h12AB_5678);
        check_all("byte");
        cycle();
        bus.log_ready = 1'b0;
        #1;
        chk("byte.drained", 32'(bus.log_valid), 32'h0);

        // Overflow: nine stores into an eight-deep log.
        for (int i = 0; i < 9; i++) begin
            drive_store(32'(i * 4), $urandom, 4'hF, IM_BASE + 32'(i * 4));
            cycle();
        end
        bus.m_data_byteen = 4'h0;
        #1;
        chk("ovf.drop", 32'(bus.log_drop), 32'h1);
        check_all("ovf");
        bus.log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf.order", bus.log_addr, 32'(i * 4));
            check_all("ovf.drain");
            cycle();
        end
        bus.log_ready = 1'b0;
        chk("ovf.empty", 32'(bus.log_valid), 32'h0);

        // Fill to eight, then push and pop in the same cycle.
        for (int i = 0; i < 8; i++) begin
            drive_store(32'h40 + 32'(i * 4), $urandom, 4'hF, IM_BASE + 32'h100);
            cycle();
        end
        drive_store(32'h60, $urandom, 4'hF, IM_BASE + 32'h104);
        bus.log_ready = 1'b1;
        cycle();
        bus.m_data_byteen = 4'h0;
        bus.log_ready     = 1'b0;
        #1;
        chk("pp.drop", 32'(bus.log_drop), 32'h1);
        chk("pp.head", bus.log_addr,      32'h44);
        check_all("pp");
        bus.log_ready = 1'b1;
        n = 0;
        while (bus.log_valid && n < 20) begin
            n++;
            cycle();
        end
        bus.log_ready = 1'b0;
        chk("pp.count", 32'(n), 32'd8);

        // Out-of-range store.
        prior = ref_read(32'h0);
        drive_store(32'h3000, $urandom, 4'hF, 32'h3100);
        cycle();
        bus.m_data_byteen = 4'h0;
        bus.m_data_addr   = 32'h0;
        #1;
        chk("oor.err",   32'(bus.err_count), 32'h1);
        chk("oor.valid", 32'(bus.log_valid), 32'h0);
        chk("oor.rdata", bus.m_data_rdata,   prior);

        // Last byte of the data RAM is still in range.
        drive_store(32'(DM_WORDS * 4 - 1), 32'hA500_0000, 4'b1000, 32'h3104);
        cycle();
        bus.m_data_byteen = 4'h0;
        bus.m_data_addr   = 32'(DM_WORDS * 4 - 4);
        #1;
        chk("top.rdata", bus.m_data_rdata, 32'hA500_0000);
        check_all("top");
        bus.log_ready = 1'b1;
        cycle();
        bus.log_ready = 1'b0;

        // Fetch window.
        bus.i_inst_addr = IM_BASE;
        #1 chk("fetch.base", bus.i_inst_rdata, 32'h3C01_0001);
        bus.i_inst_addr = 32'h2FFC;
        #1 chk("fetch.below", bus.i_inst_rdata, 32'h0);
        bus.i_inst_addr = 32'h3002;
        #1 chk("fetch.misaligned", bus.i_inst_rdata, 32'h0);
        bus.i_inst_addr = IM_BASE + 32'(IM_WORDS * 4);
        #1 chk("fetch.above", bus.i_inst_rdata, 32'h0);
        bus.i_inst_addr = IM_BASE + 32'h4;
        #1 chk("fetch.word1", bus.i_inst_rdata, ref_fetch(IM_BASE + 32'h4));

        // Randomized traffic with one reset in mid-stream.
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)
                bus.m_data_addr = 32'(DM_WORDS * 4) + 32'($urandom_range(0, 255));
            else if (sel == 1)
                bus.m_data_addr = 32'(DM_WORDS * 4 - 1) - 32'($urandom_range(0, 7));
            else
                bus.m_data_addr = 32'($urandom_range(0, 255));
            bus.m_data_byteen = ($urandom_range(0, 15) < 6) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.m_data_wdata  = $urandom;
            bus.m_inst_addr   = IM_BASE + 32'($urandom_range(0, 1023) * 4);
            bus.i_inst_addr   = IM_BASE - 32'd8 + 32'($urandom_range(0, 71));
            if ((k % 100) < 50) bus.log_ready = ($urandom_range(0, 3) == 0);
            else                bus.log_ready = ($urandom_range(0, 3) != 0);
            if (k == 200) begin
                reset = 1'b1;
                model_clear();
            end
            #1;
            check_all("rand");
            cycle();
            if (reset) begin
                reset = 1'b0;
                #1;
            end
        end

        // Drop counter saturation.
        bus.m_data_byteen = 4'h0;
        reset = 1'b1;
        model_clear();
        cycle();
        reset = 1'b0;
        bus.log_ready = 1'b0;
        for (int i = 0; i < 268; i++) begin
            drive_store(32'((i % 64) * 4), $urandom, 4'hF, IM_BASE);
            cycle();
        end
        bus.m_data_byteen = 4'h0;
        #1;
        chk("sat.drop", 32'(bus.log_drop), 32'd255);
        check_all("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
